// File: rtl/cpu_mem_pkg.sv
// Shared types and lane/extension helpers for the cpu_mem_ws MEM stage.
package cpu_mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DM   = 2'd1,
        WB_PC   = 2'd2,
        WB_ZERO = 2'd3
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [3:0] lane_mask(input mem_op_e op, input logic [1:0] off);
        case (op)
            MEM_SB:  lane_mask = 4'b0001 << off;
            MEM_SH:  lane_mask = off[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Store data is replicated so each enabled lane sees its own slice.
    function automatic logic [31:0] store_lanes(input mem_op_e op, input logic [31:0] data);
        case (op)
            MEM_SB:  store_lanes = {4{data[7:0]}};
            MEM_SH:  store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input mem_op_e op, input logic [31:0] word,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  load_ext = {{24{b[7]}}, b};
            MEM_LBU: load_ext = {24'd0, b};
            MEM_LH:  load_ext = {{16{h[15]}}, h};
            MEM_LHU: load_ext = {16'd0, h};
            MEM_LW:  load_ext = word;
            default: load_ext = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_ws_dm_byte_ram.sv
// Byte-lane data RAM: synchronous write, read word captured on launch and
// held for the load latency window, plus an asynchronous port for zero-wait loads.
module dm_byte_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              rd_launch,
    output logic [31:0]       rd_async,
    output logic [31:0]       rd_held
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_launch ? mem_q[addr] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_async = mem_q[addr];
    assign rd_held  = rd_data_q;

endmodule

// File: rtl/cpu_mem_ws.sv
// MEM pipeline stage with wait-state data memory and registered WB bundle.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module cpu_mem_ws
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [3:0]        mem_op,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] current_pc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              reg_write_en,
    input  logic [4:0]        reg_write_num,
    output logic              stall,
    output logic              reg_write_en_mem,
    output logic [4:0]        reg_write_num_mem,
    output logic [DATA_W-1:0] dm_read_data,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              misalign
);

    localparam bit       NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    mem_op_e           op;
    wb_sel_e           wsel;
    logic [1:0]        off;
    logic [ADDR_W-1:0] widx;
    logic              unused_addr_hi;

    assign op             = mem_op_e'(mem_op);
    assign wsel           = wb_sel_e'(wb_sel);
    assign off            = alu_result[1:0];
    assign widx           = alu_result[ADDR_W+1:2];
    assign unused_addr_hi = ^alu_result[DATA_W-1:ADDR_W+2];

    logic mis;
`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        mis = 1'b0;
        if (in_valid) begin
            case (op)
                MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
                MEM_LW, MEM_SW:          mis = |off;
                default:                 mis = 1'b0;
            endcase
        end
    end
`else
    assign mis = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ld, st, ld_done, stall_c;
    logic [31:0] rd_async, rd_held, ld_word, ext;

    assign ld = in_valid & is_load(op) & ~mis;
    assign st = in_valid & is_store(op) & ~mis;

    always_comb begin
        stall_c = 1'b0;
        ld_done = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    if (NO_WAIT) begin
                        ld_done = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    ld_done = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The async reset forces IDLE, so stall must also be masked while clr is high.
    assign stall = stall_c & ~clr;

    dm_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .we        ((st && state_q == ST_IDLE) ? lane_mask(op, off) : 4'b0000),
        .addr      (widx),
        .wdata     (store_lanes(op, store_data)),
        .rd_launch (ld && state_q == ST_IDLE),
        .rd_async  (rd_async),
        .rd_held   (rd_held)
    );

    assign ld_word = NO_WAIT ? rd_async : rd_held;
    assign ext     = load_ext(op, ld_word, off);

    logic              wr_en_d;
    logic [4:0]        wr_num_d;
    logic [DATA_W-1:0] dm_d, wb_data_d;
    logic              mis_d;

    // Stalled cycles register a bubble so the load writes back exactly once.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_num_d  = 5'd0;
        dm_d      = '0;
        wb_data_d = '0;
        mis_d     = 1'b0;
        if (!stall_c) begin
            wr_en_d  = in_valid & reg_write_en & ~mis;
            wr_num_d = reg_write_num;
            dm_d     = ld_done ? ext : '0;
            mis_d    = mis;
            case (wsel)
                WB_ALU:  wb_data_d = alu_result;
                WB_DM:   wb_data_d = ext;
                WB_PC:   wb_data_d = current_pc + 1'b1;
                default: wb_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q           <= ST_IDLE;
            cnt_q             <= 4'd0;
            reg_write_en_mem  <= 1'b0;
            reg_write_num_mem <= 5'd0;
            dm_read_data      <= '0;
            reg_write_data    <= '0;
            misalign          <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            reg_write_en_mem  <= wr_en_d;
            reg_write_num_mem <= wr_num_d;
            dm_read_data      <= dm_d;
            reg_write_data    <= wb_data_d;
            misalign          <= mis_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_ws.sv
// Directed bench for cpu_mem_ws: WAIT_CYCLES=2 instance for the main sequence,
// WAIT_CYCLES=3 instance for the reset-during-load scenario.
module tb_cpu_mem_ws;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        clr2 = 1'b1;
    logic        clr3 = 1'b1;
    logic        sel3 = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  mem_op = MEM_NONE;
    logic [1:0]  wb_sel = WB_ALU;
    logic [31:0] current_pc = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        reg_write_en = 1'b0;
    logic [4:0]  reg_write_num = '0;

    logic        stall2, en2, mis2, stall3, en3, mis3;
    logic [4:0]  num2, num3;
    logic [31:0] dm2, data2, dm3, data3;

    int errors = 0;
    int checks = 0;
    int stalls;

    always #5 clk = ~clk;

    cpu_mem_ws #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .clr(clr2), .in_valid(in_valid), .mem_op(mem_op), .wb_sel(wb_sel),
        .current_pc(current_pc), .alu_result(alu_result), .store_data(store_data),
        .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .stall(stall2),
        .reg_write_en_mem(en2), .reg_write_num_mem(num2), .dm_read_data(dm2),
        .reg_write_data(data2), .misalign(mis2)
    );

    cpu_mem_ws #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr3), .in_valid(in_valid), .mem_op(mem_op), .wb_sel(wb_sel),
        .current_pc(current_pc), .alu_result(alu_result), .store_data(store_data),
        .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .stall(stall3),
        .reg_write_en_mem(en3), .reg_write_num_mem(num3), .dm_read_data(dm3),
        .reg_write_data(data3), .misalign(mis3)
    );

    wire        s_stall = sel3 ? stall3 : stall2;
    wire        s_en    = sel3 ? en3    : en2;
    wire [4:0]  s_num   = sel3 ? num3   : num2;
    wire [31:0] s_dm    = sel3 ? dm3    : dm2;
    wire [31:0] s_data  = sel3 ? data3  : data2;
    wire        s_mis   = sel3 ? mis3   : mis2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input mem_op_e op, input wb_sel_e wb, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic we, input logic [4:0] num);
        in_valid      = 1'b1;
        mem_op        = op;
        wb_sel        = wb;
        current_pc    = pc;
        alu_result    = alu;
        store_data    = sd;
        reg_write_en  = we;
        reg_write_num = num;
    endtask

    task automatic go_idle();
        in_valid     = 1'b0;
        mem_op       = MEM_NONE;
        reg_write_en = 1'b0;
    endtask

    // Holds the current inputs until stall drops, then lets the result register.
    task automatic run(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!s_stall) break;
            n++;
            @(posedge clk); #1;
            chk("bubble_en", {31'd0, s_en}, 32'd0);
            chk("bubble_data", s_data, 32'd0);
        end
        chk("stall_budget", {31'd0, s_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a load presented so stall masking is exercised.
        drive(MEM_LW, WB_DM, 32'h0, 32'h10, 32'h0, 1'b1, 5'd1);
        #12;
        chk("rst_stall", {31'd0, stall2}, 32'd0);
        chk("rst_en", {31'd0, en2}, 32'd0);
        chk("rst_data", data2, 32'd0);
        chk("rst_dm", dm2, 32'd0);
        chk("rst_mis", {31'd0, mis2}, 32'd0);
        go_idle();
        clr2 = 1'b0;
        @(posedge clk); #1;

        drive(MEM_NONE, WB_ALU, 32'h0, 32'h1234, 32'h0, 1'b1, 5'd3);
        run(stalls);
        chk("alu_stalls", stalls, 0);
        chk("alu_data", s_data, 32'h1234);
        chk("alu_en", {31'd0, s_en}, 32'd1);
        chk("alu_num", {27'd0, s_num}, 32'd3);

        drive(MEM_SW, WB_ALU, 32'h0, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
        run(stalls);
        chk("sw_stalls", stalls, 0);
        chk("sw_en", {31'd0, s_en}, 32'd0);

        drive(MEM_LW, WB_DM, 32'h0, 32'h10, 32'h0, 1'b1, 5'd5);
        run(stalls);
        chk("lw_stalls", stalls, 2);
        chk("lw_data", s_data, 32'hDEADBEEF);
        chk("lw_dm", s_dm, 32'hDEADBEEF);
        chk("lw_en", {31'd0, s_en}, 32'd1);
        chk("lw_num", {27'd0, s_num}, 32'd5);

        drive(MEM_SB, WB_ALU, 32'h0, 32'h21, 32'h80, 1'b0, 5'd0);
        run(stalls);
        drive(MEM_LB, WB_DM, 32'h0, 32'h21, 32'h0, 1'b1, 5'd6);
        run(stalls);
        chk("lb_data", s_data, 32'hFFFFFF80);
        drive(MEM_LBU, WB_DM, 32'h0, 32'h21, 32'h0, 1'b1, 5'd6);
        run(stalls);
        chk("lbu_data", s_data, 32'h00000080);
        chk("lbu_dm", s_dm, 32'h00000080);

        drive(MEM_SH, WB_ALU, 32'h0, 32'h22, 32'h8001, 1'b0, 5'd0);
        run(stalls);
        drive(MEM_LH, WB_DM, 32'h0, 32'h22, 32'h0, 1'b1, 5'd7);
        run(stalls);
        chk("lh_data", s_data, 32'hFFFF8001);
        drive(MEM_LHU, WB_DM, 32'h0, 32'h22, 32'h0, 1'b1, 5'd7);
        run(stalls);
        chk("lhu_data", s_data, 32'h00008001);
        drive(MEM_LBU, WB_DM, 32'h0, 32'h21, 32'h0, 1'b1, 5'd6);
        run(stalls);
        chk("sb_lane_kept", s_data, 32'h00000080);

        drive(MEM_NONE, WB_PC, 32'h40, 32'h99, 32'h0, 1'b1, 5'd2);
        run(stalls);
        chk("pc_data", s_data, 32'h41);
        drive(MEM_NONE, WB_ZERO, 32'h40, 32'h99, 32'h0, 1'b1, 5'd2);
        run(stalls);
        chk("zero_data", s_data, 32'h0);
        drive(MEM_NONE, WB_ALU, 32'h0, 32'h77, 32'h0, 1'b1, 5'd9);
        in_valid = 1'b0;
        run(stalls);
        chk("invalid_en", {31'd0, s_en}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        drive(MEM_LW, WB_DM, 32'h0, 32'h13, 32'h0, 1'b1, 5'd4);
        run(stalls);
        chk("mis_lw_stalls", stalls, 0);
        chk("mis_lw_flag", {31'd0, s_mis}, 32'd1);
        chk("mis_lw_en", {31'd0, s_en}, 32'd0);
        go_idle();
        @(posedge clk); #1;
        chk("mis_one_cycle", {31'd0, s_mis}, 32'd0);
        drive(MEM_SW, WB_ALU, 32'h0, 32'h13, 32'h11111111, 1'b0, 5'd0);
        run(stalls);
        drive(MEM_LW, WB_DM, 32'h0, 32'h10, 32'h0, 1'b1, 5'd4);
        run(stalls);
        chk("mis_sw_suppressed", s_data, 32'hDEADBEEF);
`else
        drive(MEM_LW, WB_DM, 32'h0, 32'h13, 32'h0, 1'b1, 5'd4);
        run(stalls);
        chk("unaligned_lw_stalls", stalls, 2);
        chk("unaligned_lw_data", s_data, 32'hDEADBEEF);
        chk("unaligned_lw_mis", {31'd0, s_mis}, 32'd0);
        chk("unaligned_lw_en", {31'd0, s_en}, 32'd1);
`endif

        // Reset in the middle of a WAIT_CYCLES=3 load.
        go_idle();
        clr2 = 1'b1;
        clr3 = 1'b0;
        sel3 = 1'b1;
        @(posedge clk); #1;
        drive(MEM_SW, WB_ALU, 32'h0, 32'h30, 32'hCAFEF00D, 1'b0, 5'd0);
        run(stalls);
        drive(MEM_LW, WB_DM, 32'h0, 32'h30, 32'h0, 1'b1, 5'd7);
        #1;
        chk("abort_stall_c1", {31'd0, s_stall}, 32'd1);
        @(posedge clk); #1;
        chk("abort_stall_c2", {31'd0, s_stall}, 32'd1);
        clr3 = 1'b1;
        #1;
        chk("abort_stall_drop", {31'd0, s_stall}, 32'd0);
        chk("abort_en_clr", {31'd0, s_en}, 32'd0);
        go_idle();
        #1;
        clr3 = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_wb", {31'd0, s_en}, 32'd0);
        chk("abort_data", s_data, 32'd0);
        drive(MEM_LW, WB_DM, 32'h0, 32'h30, 32'h0, 1'b1, 5'd7);
        run(stalls);
        chk("reload_stalls", stalls, 3);
        chk("reload_data", s_data, 32'hCAFEF00D);
        chk("reload_en", {31'd0, s_en}, 32'd1);
        go_idle();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
